// File: rtl/types_pkg.sv
// Shared types, funct3 codes and byte-lane helpers for the memory-access stage.
package types_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  typedef logic [3:0] be_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Any funct3 that is neither a byte nor a halfword code is a word access.
  function automatic logic is_byte(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] f3);
    return (f3 == F3_H) || (f3 == F3_HU);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    if (is_byte(f3)) return 1'b0;
    if (is_half(f3)) return off[0];
    return |off;
  endfunction

  function automatic logic [1:0] align_offset(input logic [2:0] f3, input logic [1:0] off);
    if (is_byte(f3)) return off;
    if (is_half(f3)) return {off[1], 1'b0};
    return 2'b00;
  endfunction

  function automatic be_t access_be(input logic [2:0] f3, input logic [1:0] off);
    if (is_byte(f3)) return be_t'(4'b0001 << off);
    if (is_half(f3)) return be_t'(4'b0011 << {off[1], 1'b0});
    return 4'b1111;
  endfunction

  // Replicate store data so the byte-enabled lanes always carry the right bytes.
  function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] wd);
    if (is_byte(f3)) return {4{wd[7:0]}};
    if (is_half(f3)) return {2{wd[15:0]}};
    return wd;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select and sign/zero extension of a bus read word.
module load_extend
  import types_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = 8'h00;
    lane_half = offset[1] ? rdata[31:16] : rdata[15:0];
    data      = rdata;
    case (offset)
      2'd0:    lane_byte = rdata[7:0];
      2'd1:    lane_byte = rdata[15:8];
      2'd2:    lane_byte = rdata[23:16];
      default: lane_byte = rdata[31:24];
    endcase
    case (funct3)
      F3_B:    data = {{24{lane_byte[7]}}, lane_byte};
      F3_BU:   data = {24'h000000, lane_byte};
      F3_H:    data = {{16{lane_half[15]}}, lane_half};
      F3_HU:   data = {16'h0000, lane_half};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-stage load/store unit: request/ack bus transaction, byte lanes, load extension.
// Build macro MEM_MISALIGN_TRAP_EN rejects misaligned half/word accesses instead of aligning them.
module mem_access_stage
  import types_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_read_m,
  input  logic            mem_write_m,
  input  logic [2:0]      funct3_m,
  input  logic [XLEN-1:0] addr_m,
  input  logic [XLEN-1:0] wdata_m,
  output logic            stall_m,
  output logic [XLEN-1:0] load_data_m,
  output logic            misalign_m,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_ack
);

  mem_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] load_data_q, load_data_d;
  be_t             be_q, be_d;
  logic            we_q, we_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      off_q, off_d;
  logic [XLEN-1:0] ext_data;
  logic            access;
  logic            reject;
  logic [1:0]      req_off;

  assign access = mem_read_m | mem_write_m;

`ifdef MEM_MISALIGN_TRAP_EN
  assign reject  = access && is_misaligned(funct3_m, addr_m[1:0]);
  assign req_off = addr_m[1:0];
`else
  assign reject  = 1'b0;
  assign req_off = align_offset(funct3_m, addr_m[1:0]);
`endif

  load_extend u_load_extend (
    .funct3 (funct3_q),
    .offset (off_q),
    .rdata  (bus_rdata),
    .data   (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    be_d        = be_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    stall_m     = 1'b0;
    bus_req     = 1'b0;
    misalign_m  = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (access) begin
            if (reject) begin
              misalign_m = 1'b1;
            end else begin
              state_d  = BUSY;
              stall_m  = 1'b1;
              addr_d   = {addr_m[XLEN-1:2], 2'b00};
              be_d     = access_be(funct3_m, req_off);
              we_d     = mem_write_m;
              wdata_d  = store_lanes(funct3_m, wdata_m);
              funct3_d = funct3_m;
              off_d    = req_off;
            end
          end
        end
        // Request fields stay frozen in their registers until the ack arrives.
        BUSY: begin
          stall_m = 1'b1;
          bus_req = 1'b1;
          if (bus_ack) begin
            if (!we_q) load_data_d = ext_data;
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
      be_q        <= be_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
    end
  end

  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_be      = be_q;
  assign bus_wdata   = wdata_q;
  assign load_data_m = load_data_q;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-stage load/store unit between the EX/MEM and MEM/WB pipeline registers of the pipelined core. It turns the stage's memory controls into a request/acknowledge transaction on the data-memory bus, handles byte lanes, and sign- or zero-extends load data. While a transaction is outstanding it asserts a stall to the hazard unit.

## Interface
- XLEN, 32: data/address width; only 32 is supported.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- mem_read_m  in  1  load in memory stage
- mem_write_m  in  1  store in memory stage; never asserted together with mem_read_m
- funct3_m  in  3  access size and sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- addr_m  in  XLEN  byte address (ALUResultM)
- wdata_m  in  XLEN  store data (WriteDataM)
- stall_m  out  1  hold IF/ID/EX/MEM registers, bubble MEM/WB
- load_data_m  out  XLEN  extended load result (ReadDataM)
- misalign_m  out  1  misaligned-access flag (see Configuration)
- bus_req  out  1  request valid
- bus_we  out  1  1 = write
- bus_addr  out  XLEN  word address, {addr_m[31:2], 2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  XLEN  lane-replicated store data
- bus_rdata  in  XLEN  read data, valid in the bus_ack cycle
- bus_ack  in  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, BUSY, DONE. Reset value is IDLE.
- Output reset values: bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, load_data_m=0, stall_m=0, misalign_m=0.
- IDLE:
  - If (mem_read_m|mem_write_m) and the access is not rejected: register addr/be/we/wdata/funct3, assert stall_m, go to BUSY.
  - Otherwise stay in IDLE with stall_m=0.
- BUSY:
  - bus_req=1. Registered request fields are held stable until ack.
  - stall_m=1.
  - On bus_ack: capture bus_rdata (loads only), go to DONE.
- DONE:
  - stall_m=0. load_data_m holds the extended value.
  - The pipeline advances at the end of this cycle. Next state is IDLE.
  - A new access can be accepted the following cycle.
- bus_ack outside BUSY is ignored.
- Store byte enables:
  - SB: be = 4'b0001 << addr[1:0], byte replicated on all four lanes.
  - SH: be = 4'b0011 << {addr[1],1'b0}, halfword replicated on both halves.
  - SW: be = 4'b1111.
- Load extraction selects the lane by addr[1:0]:
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: full word.
- Unlisted funct3 codes are treated as word accesses.
- The stage is never flushed. A store, once issued, always completes.
- Reset mid-transaction: go to IDLE and drop bus_req the next cycle. A late bus_ack is ignored.

## Timing
- Zero-wait memory (ack in the first BUSY cycle): 2 stall cycles per access. The result is valid in DONE, 2 cycles after acceptance.
- N wait cycles add N stall cycles.
- Non-memory instructions: 0 stall, no bus activity.
- load_data_m is registered, so there is no combinational path from bus_rdata to the MEM/WB register.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, is rejected. No bus request is made and no stall occurs.
  - misalign_m=1 for that cycle (combinational). load_data_m keeps its previous value.
- MEM_MISALIGN_TRAP_EN undefined:
  - misalign_m is tied 0.
  - The offending low address bits are cleared (halfword: addr[0]; word: addr[1:0]) and the access proceeds aligned.

## Structure
- In types_pkg: mem_state_e (IDLE/BUSY/DONE), funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), and the byte-enable type be_t (logic [3:0]).
- One sub-module, load_extend: combinational lane select plus sign/zero extension (funct3, addr[1:0], rdata -> data).

## Test plan
- LW at addr 0x10, memory word 0x8765_4321, ack in first BUSY cycle -> stall_m high 2 cycles; bus_addr=0x10, be=1111; load_data_m=0x8765_4321 in DONE.
- SB at addr 0x13, wdata 0x0000_00AB, ack after 3 wait cycles -> bus_we=1, be=1000, bus_wdata=0xABAB_ABAB held stable; stall_m high 5 cycles.
- LB at 0x22 over word 0x00F0_0000 -> 0xFFFF_FFF0; LBU at the same address -> 0x0000_00F0; LHU at 0x22 -> 0x0000_00F0.
- Reset asserted in BUSY, then a stray bus_ack -> state IDLE, bus_req=0, stall_m=0, no capture.
- With MEM_MISALIGN_TRAP_EN, LW at 0x06 -> misalign_m=1, bus_req stays 0, stall_m=0. Without the macro -> bus_addr=0x04, be=1111, normal completion.
- Back-to-back SW then LW to the same address 0x40 (0xDEAD_BEEF) -> second request issues the cycle after DONE; the load returns 0xDEAD_BEEF.
